// File: rtl/offload_pkg.sv
// offload_pkg: shared types, defaults and tag-width helper for the offload arbiter
package offload_pkg;
  localparam int MAX_OUT_DEF = 4;
  localparam int W_DEF = 32;
  localparam int TAG_W_DEF = 2;
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic [W_DEF-1:0] bits;
  } off_msg_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting at a rotating pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr, win, idx;
  logic [PW:0] sum;
  logic found;
  // scan from ptr upward, wrapping modulo N, and take the first active request
  always_comb begin
    grant = '0;
    win = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      idx = PW'((sum >= (PW+1)'(N)) ? sum - (PW+1)'(N) : sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        win = idx;
      end
    end
  end
  // pointer moves just past the winner so it becomes lowest priority next time
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (advance) ptr <= (win == PW'(N-1)) ? '0 : win + PW'(1);
endmodule

// File: rtl/offload_arbiter.sv
// offload_arbiter: shares one offload engine among N requesters with credit-bounded issue
module offload_arbiter
  import offload_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32,
  parameter int TAG_W = tag_w(N),
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_bits,
  output logic [N-1:0]     req_ready,
  output logic [N-1:0]     resp_valid,
  output logic [W-1:0]     resp_bits,
  input  logic [N-1:0]     resp_ready,
  output logic             off_req_valid,
  output logic [W-1:0]     off_req_bits,
  output logic [TAG_W-1:0] off_req_tag,
  input  logic             off_req_ready,
  input  logic             off_resp_valid,
  input  logic [W-1:0]     off_resp_bits,
  input  logic [TAG_W-1:0] off_resp_tag,
  output logic             off_resp_ready,
  output logic [3:0]       outstanding,
  output logic             busy
);
  logic [3:0] credits;
  logic allow, grant_any, tag_ok, resp_hs;
  logic [W-1:0] sel_bits;
  logic [TAG_W-1:0] sel_tag;
  assign allow = reset && (!off_req_valid || off_req_ready) && credits != 4'd0;
  rr_arbiter #(.N(N)) u_rr (
    .clk(clk),
    .reset(reset),
    .req(allow ? req_valid : '0),
    .advance(grant_any),
    .grant(req_ready)
  );
  assign grant_any = |req_ready;
  assign tag_ok = int'(off_resp_tag) < N;
  assign off_resp_ready = reset && (tag_ok ? resp_ready[off_resp_tag] : 1'b1);
  assign resp_bits = reset ? off_resp_bits : '0;
  assign resp_hs = off_resp_valid && off_resp_ready;
  assign outstanding = 4'(MAX_OUT) - credits;
  assign busy = outstanding != 4'd0 || off_req_valid;
  // payload and tag of the granted requester
  always_comb begin
    sel_bits = '0;
    sel_tag = '0;
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin
        sel_bits = req_bits[i*W +: W];
        sel_tag = TAG_W'(i);
      end
  end
  // route the engine response to the requester named by its tag
  always_comb begin
    resp_valid = '0;
    if (reset && off_resp_valid && tag_ok) resp_valid[off_resp_tag] = 1'b1;
  end
  // credits are taken at grant and returned at response handshake
  always_ff @(posedge clk or negedge reset)
    if (!reset) credits <= 4'(MAX_OUT);
    else if (grant_any && !resp_hs) credits <= credits - 4'd1;
    else if (resp_hs && !grant_any && credits != 4'(MAX_OUT)) credits <= credits + 4'd1;
  // single-entry output register toward the engine
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      off_req_valid <= 1'b0;
      off_req_bits <= '0;
      off_req_tag <= '0;
    end else if (grant_any) begin
      off_req_valid <= 1'b1;
      off_req_bits <= sel_bits;
      off_req_tag <= sel_tag;
    end else if (off_req_ready) off_req_valid <= 1'b0;
  // protocol checks on the engine response side
  always_ff @(posedge clk)
    if (reset && off_resp_valid) begin
      assert (tag_ok);
      assert (!(resp_hs && credits == 4'(MAX_OUT)));
    end
endmodule

// File: doc/offload_arbiter.md
Name: offload_arbiter

Overview:
- Shares one offload engine (the increment-through-offload datapath, ready/valid 32-bit in/out) among N requester ports.
- Round-robin arbitration on the request side; requester ID is carried as a tag; responses are routed back to the requester named by the tag.
- A credit counter bounds the number of transactions in flight inside the engine.
- Sits between requester cores and the engine inside Top.

Parameters:
- N, 4, number of requester ports (2..8).
- W, 32, data width of request and response payloads.
- TAG_W, 2, tag width, equal to clog2(N).
- MAX_OUT, 4, maximum engine transactions in flight (1..15).

Ports:
- clk  in  1  clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N  per-requester request valid.
- req_bits  in  N*W  requester i uses slice [i*W +: W].
- req_ready  out  N  per-requester accept; one-hot or zero.
- resp_valid  out  N  per-requester response valid; one-hot or zero.
- resp_bits  out  W  response payload, shared by all requesters.
- resp_ready  in  N  per-requester response ready.
- off_req_valid  out  1  request to engine, registered.
- off_req_bits  out  W  registered payload.
- off_req_tag  out  TAG_W  registered requester ID.
- off_req_ready  in  1  engine accepts the request.
- off_resp_valid  in  1  engine response valid.
- off_resp_bits  in  W  engine response payload.
- off_resp_tag  in  TAG_W  tag returned by the engine.
- off_resp_ready  out  1  arbiter accepts the engine response.
- outstanding  out  4  transactions currently in flight.
- busy  out  1  high when outstanding != 0 or off_req_valid is high.

Behaviour:
- Reset (reset low, asynchronous):
  - off_req_valid=0; off_req_bits=0; off_req_tag=0.
  - rr_ptr=0; credits=MAX_OUT; outstanding=0.
  - All combinational outputs evaluate to 0.
- Output register: a single entry (off_req_valid/bits/tag).
  - Can load this cycle when !off_req_valid || off_req_ready.
- Grant, combinational:
  - Grant is allowed when the output register can load and credits != 0.
  - Winner is the first set req_valid bit at or after rr_ptr, wrapping modulo N.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - No grant when no requester is valid, credits==0, or the output register is blocked.
- Latency: a req handshake in cycle t gives off_req_valid=1 with that payload and tag from cycle t+1. Throughput is 1 per cycle while off_req_ready stays high.
- rr_ptr: on a grant to i, rr_ptr <= (i+1) mod N. Otherwise unchanged.
- Output register update:
  - Grant: load payload/tag, valid=1.
  - No grant and off_req_ready: valid=0.
  - Otherwise hold.
  - Bits and tag stay stable while valid && !ready.
- Credits are counted at grant time, not at engine handshake:
  - Grant only: credits-1.
  - Response handshake only: credits+1.
  - Both in the same cycle: unchanged.
  - outstanding = MAX_OUT - credits. It therefore includes the request held in the output register.
- Response routing, combinational and non-buffered:
  - resp_valid[off_resp_tag] = off_resp_valid; resp_bits = off_resp_bits.
  - off_resp_ready = resp_ready[off_resp_tag].
  - A stalled requester back-pressures the engine.
  - A tag >= N is a protocol error: off_resp_ready=1 (drain), no resp_valid, credit still returned. A simulation assertion fires.
- Credit limits:
  - A response with credits==MAX_OUT is an error: assert, and the credit saturates.
  - credits never goes below 0, because no grant is made at 0.
- Reset mid-operation: all in-flight state is dropped. The engine must be reset concurrently.

Decomposition:
- Shared package offload_pkg holds:
  - the TAG_W derivation function (clog2);
  - the MAX_OUT default;
  - a packed struct {tag, bits} for the offload request/response.
- One sub-module rr_arbiter (N-bit request in, one-hot grant out, rr_ptr state, advance input).
- Credit counter, output register and response demux stay in offload_arbiter.

Test Plan:
1. Single requester: req_valid=0001, bits=5, engine returns bits+1 with the same tag after 3 cycles -> off_req_valid at t+1 with tag 0, resp_valid=0001 with resp_bits=6, outstanding returns to 0.
2. All four requesters valid continuously, off_req_ready=1, engine returns each response after 1 cycle -> grant order 0,1,2,3,0,...; each requester gets an equal share (±1) over 100 grants.
3. Engine never responds, N=4, MAX_OUT=4 -> exactly 4 grants, then req_ready=0000, outstanding=4, busy=1. Issuing one response gives exactly one further grant.
4. off_req_ready held low 5 cycles with valid=1 -> off_req_bits/tag stable; no further grants; rr_ptr unchanged.
5. Response tag=2 with resp_ready=1011 -> off_resp_ready=0 and the engine stalls. Raising resp_ready[2] completes the handshake in that cycle.
6. Grant and response handshake in the same cycle at credits=1 -> credits stays 1. Asserting reset low mid-burst -> all outputs 0 immediately, credits=4 after reset is released.
